// File: rtl/dcache_pkg.sv
// Shared types and address-field helpers for the direct-mapped write-back data cache.
package dcache_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WB,
        FILL,
        RESP
    } state_t;

    localparam logic [2:0] MASK_B   = 3'b000;
    localparam logic [2:0] MASK_H   = 3'b001;
    localparam logic [2:0] MASK_W   = 3'b010;
    localparam logic [2:0] MASK_BU  = 3'b100;
    localparam logic [2:0] MASK_HU  = 3'b101;
    localparam logic [2:0] MEM_MASK = MASK_W;

    localparam int OFFSET_BITS = 2;

    function automatic int word_bits(input int words);
        return $clog2(words);
    endfunction

    function automatic int index_bits(input int lines);
        return $clog2(lines);
    endfunction

    function automatic int tag_bits(input int lines, input int words);
        return 32 - OFFSET_BITS - word_bits(words) - index_bits(lines);
    endfunction

endpackage

// File: rtl/dcache_ctrl_lsu_lane.sv
// Byte/halfword/word lane logic: load extraction with extension and store merging.
module lsu_lane
    import dcache_pkg::*;
(
    input  logic [31:0] old_word,
    input  logic [1:0]  lane,
    input  logic [2:0]  mask,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic [31:0] new_word,
    output logic        store_ok
);

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    always_comb begin
        sel_byte = old_word[{lane, 3'b000} +: 8];
        sel_half = lane[1] ? old_word[31:16] : old_word[15:0];
        rdata    = '0;
        new_word = old_word;
        store_ok = 1'b0;

        case (mask)
            MASK_B:  rdata = {{24{sel_byte[7]}}, sel_byte};
            MASK_H:  rdata = {{16{sel_half[15]}}, sel_half};
            MASK_W:  rdata = old_word;
            MASK_BU: rdata = {24'd0, sel_byte};
            MASK_HU: rdata = {16'd0, sel_half};
            default: rdata = '0;
        endcase

        // Unsigned masks are load-only; a store with them leaves the word untouched
        case (mask)
            MASK_B: begin
                new_word[{lane, 3'b000} +: 8] = wdata[7:0];
                store_ok = 1'b1;
            end
            MASK_H: begin
                if (lane[1])
                    new_word[31:16] = wdata[15:0];
                else
                    new_word[15:0] = wdata[15:0];
                store_ok = 1'b1;
            end
            MASK_W: begin
                new_word = wdata;
                store_ok = 1'b1;
            end
            default: store_ok = 1'b0;
        endcase
    end

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate data cache controller with
// word-by-word victim write-back and line refill.
module dcache_ctrl
    import dcache_pkg::*;
#(
    parameter int LINES = 16,
    parameter int WORDS = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wr,
    input  logic [2:0]  req_mask,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        mem_rd_en,
    output logic        mem_wr_en,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [2:0]  mem_mask,
    input  logic [31:0] mem_rdata
);

    localparam int WORD_W = word_bits(WORDS);
    localparam int IDX_W  = index_bits(LINES);
    localparam int TAG_W  = tag_bits(LINES, WORDS);
    localparam int IDX_LO = OFFSET_BITS + WORD_W;
    localparam int TAG_LO = IDX_LO + IDX_W;
    localparam logic [WORD_W-1:0] FIRST_BEAT = '0;
    localparam logic [WORD_W-1:0] LAST_BEAT  = WORD_W'(WORDS - 1);

    state_t            state;
    logic [WORD_W-1:0] beat;
    logic [WORD_W-1:0] beat_nxt;
    logic              last_beat;
    logic [LINES-1:0]  valid_q;
    logic [LINES-1:0]  dirty_q;
    logic [TAG_W-1:0]  tag_q  [LINES];
    logic [31:0]       data_q [LINES][WORDS];

    logic [31:0] cap_addr;
    logic [31:0] cap_wdata;
    logic [2:0]  cap_mask;
    logic        cap_wr;

    logic [31:0]       lk_addr;
    logic [31:0]       lk_wdata;
    logic [2:0]        lk_mask;
    logic              lk_wr;
    logic [IDX_W-1:0]  lk_idx;
    logic [WORD_W-1:0] lk_word;
    logic [TAG_W-1:0]  lk_tag;
    logic              lk_hit;
    logic [31:0]       lk_old;
    logic [31:0]       lane_rdata;
    logic [31:0]       lane_word;
    logic [31:0]       load_data;
    logic              store_ok;
    logic              store_commit;

    assign mem_mask = MEM_MASK;

    // In IDLE the lookup sees the live request; afterwards it replays the captured one,
    // with the word arriving on the final refill beat bypassed in from memory.
    always_comb begin
        lk_addr  = (state == IDLE) ? req_addr  : cap_addr;
        lk_wdata = (state == IDLE) ? req_wdata : cap_wdata;
        lk_mask  = (state == IDLE) ? req_mask  : cap_mask;
        lk_wr    = (state == IDLE) ? req_wr    : cap_wr;
        lk_idx   = lk_addr[TAG_LO-1:IDX_LO];
        lk_word  = lk_addr[IDX_LO-1:OFFSET_BITS];
        lk_tag   = lk_addr[31:TAG_LO];
        lk_hit   = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
        lk_old   = data_q[lk_idx][lk_word];
        if (state == FILL && lk_word == beat)
            lk_old = mem_rdata;
        beat_nxt  = beat + 1'b1;
        last_beat = (beat == LAST_BEAT);
        load_data = lk_wr ? 32'd0 : lane_rdata;
        store_commit = lk_wr && store_ok &&
                       ((state == IDLE && req_valid && lk_hit) ||
                        (state == FILL && last_beat));
    end

    lsu_lane u_lane (
        .old_word (lk_old),
        .lane     (lk_addr[1:0]),
        .mask     (lk_mask),
        .wdata    (lk_wdata),
        .rdata    (lane_rdata),
        .new_word (lane_word),
        .store_ok (store_ok)
    );

    // Line storage carries no reset: validity alone decides whether contents mean anything
    always_ff @(posedge clk) begin
        if (state == FILL) begin
            data_q[lk_idx][beat] <= mem_rdata;
            if (last_beat)
                tag_q[lk_idx] <= lk_tag;
        end
        if (store_commit)
            data_q[lk_idx][lk_word] <= lane_word;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            beat       <= '0;
            valid_q    <= '0;
            dirty_q    <= '0;
            cap_addr   <= '0;
            cap_wdata  <= '0;
            cap_mask   <= '0;
            cap_wr     <= 1'b0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            mem_rd_en  <= 1'b0;
            mem_wr_en  <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
        end else begin
            resp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        cap_addr  <= req_addr;
                        cap_wdata <= req_wdata;
                        cap_mask  <= req_mask;
                        cap_wr    <= req_wr;
                        beat      <= '0;
                        req_ready <= 1'b0;
                        if (lk_hit) begin
                            if (store_commit)
                                dirty_q[lk_idx] <= 1'b1;
                            resp_valid <= 1'b1;
                            resp_rdata <= load_data;
                            state      <= RESP;
                        end else if (valid_q[lk_idx] && dirty_q[lk_idx]) begin
                            mem_wr_en <= 1'b1;
                            mem_addr  <= {tag_q[lk_idx], lk_idx, FIRST_BEAT, 2'b00};
                            mem_wdata <= data_q[lk_idx][FIRST_BEAT];
                            state     <= WB;
                        end else begin
                            mem_rd_en <= 1'b1;
                            mem_addr  <= {lk_tag, lk_idx, FIRST_BEAT, 2'b00};
                            state     <= FILL;
                        end
                    end
                end
                WB: begin
                    beat <= beat_nxt;
                    if (last_beat) begin
                        dirty_q[lk_idx] <= 1'b0;
                        mem_wr_en <= 1'b0;
                        mem_wdata <= '0;
                        mem_rd_en <= 1'b1;
                        mem_addr  <= {lk_tag, lk_idx, FIRST_BEAT, 2'b00};
                        state     <= FILL;
                    end else begin
                        mem_addr  <= {tag_q[lk_idx], lk_idx, beat_nxt, 2'b00};
                        mem_wdata <= data_q[lk_idx][beat_nxt];
                    end
                end
                FILL: begin
                    beat <= beat_nxt;
                    if (last_beat) begin
                        valid_q[lk_idx] <= 1'b1;
                        dirty_q[lk_idx] <= store_commit;
                        mem_rd_en  <= 1'b0;
                        mem_addr   <= '0;
                        resp_valid <= 1'b1;
                        resp_rdata <= load_data;
                        state      <= RESP;
                    end else begin
                        mem_addr <= {lk_tag, lk_idx, beat_nxt, 2'b00};
                    end
                end
                RESP: begin
                    req_ready  <= 1'b1;
                    resp_rdata <= '0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Self-checking bench: a line-level cache/memory model predicts every cycle of each access.
module tb_dcache_ctrl;

    localparam int LINES     = 16;
    localparam int WORDS     = 4;
    localparam int MEM_WORDS = 4096;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_wr;
    logic [2:0]  req_mask;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        mem_rd_en;
    logic        mem_wr_en;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [2:0]  mem_mask;
    logic [31:0] mem_rdata;

    typedef struct {
        bit          ready;
        bit          resp;
        logic [31:0] rdata;
        bit          rd;
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] mem     [MEM_WORDS];
    logic [31:0] ref_mem [MEM_WORDS];
    bit          m_valid [LINES];
    bit          m_dirty [LINES];
    logic [31:0] m_tag   [LINES];

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          accept_cyc = 0;
    int          last_lat = 0;
    logic [31:0] last_rdata = '0;
    bit          check_en = 1'b0;

    dcache_ctrl #(.LINES(LINES), .WORDS(WORDS)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_wr     (req_wr),
        .req_mask   (req_mask),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .mem_rd_en  (mem_rd_en),
        .mem_wr_en  (mem_wr_en),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_mask   (mem_mask),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] initWord(input int i);
        if (i == 32'h100 / 4)
            return 32'h80FF_7F01;
        return 32'(32'h9E37_79B9 * (i + 1));
    endfunction

    // Backing memory: answers reads combinationally, commits writes at the clock edge
    initial begin
        for (int i = 0; i < MEM_WORDS; i++) mem[i] = initWord(i);
        forever begin
            @(posedge clk);
            if (mem_wr_en) mem[mem_addr[13:2]] = mem_wdata;
        end
    end
    assign mem_rdata = mem[mem_addr[13:2]];

    function automatic logic [31:0] loadExtract(input logic [31:0] w, input logic [31:0] addr,
                                                input logic [2:0] mask);
        logic [31:0] b;
        logic [31:0] h;
        b = (w >> (8 * addr[1:0])) & 32'hFF;
        h = (w >> (16 * addr[1])) & 32'hFFFF;
        case (mask)
            3'b000:  return (b >= 32'h80)   ? b - 32'h100   : b;
            3'b001:  return (h >= 32'h8000) ? h - 32'h10000 : h;
            3'b010:  return w;
            3'b100:  return b;
            3'b101:  return h;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] storeMerge(input logic [31:0] w, input logic [31:0] addr,
                                               input logic [2:0] mask, input logic [31:0] wdata);
        logic [31:0] sel;
        int          sh;
        case (mask)
            3'b000:  begin sh = 8 * addr[1:0]; sel = 32'hFF << sh;   end
            3'b001:  begin sh = 16 * addr[1];  sel = 32'hFFFF << sh; end
            3'b010:  begin sh = 0;             sel = 32'hFFFF_FFFF;  end
            default: begin sh = 0;             sel = 32'h0;          end
        endcase
        return (w & ~sel) | ((wdata << sh) & sel);
    endfunction

    function automatic exp_t quietCycle(input bit ready);
        exp_t e;
        e.ready = ready;
        e.resp  = 1'b0;
        e.rdata = '0;
        e.rd    = 1'b0;
        e.wr    = 1'b0;
        e.addr  = '0;
        e.wdata = '0;
        return e;
    endfunction

    // Predict the full cycle trace of one access from the line-level cache state
    task automatic modelRequest(input bit wr, input logic [2:0] mask, input logic [31:0] addr,
                                input logic [31:0] wdata);
        int          idx;
        logic [31:0] tag;
        logic [31:0] base;
        logic [31:0] wa;
        logic [31:0] w;
        exp_t        e;
        idx = (addr >> 4) % LINES;
        tag = addr >> 8;
        exp_q.push_back(quietCycle(1'b1));
        if (!(m_valid[idx] && m_tag[idx] == tag)) begin
            if (m_valid[idx] && m_dirty[idx]) begin
                base = (m_tag[idx] << 8) | (idx << 4);
                for (int k = 0; k < WORDS; k++) begin
                    wa = base + 4 * k;
                    e = quietCycle(1'b0);
                    e.wr = 1'b1;
                    e.addr = wa;
                    e.wdata = ref_mem[wa[13:2]];
                    exp_q.push_back(e);
                end
            end
            base = addr & ~32'hF;
            for (int k = 0; k < WORDS; k++) begin
                e = quietCycle(1'b0);
                e.rd = 1'b1;
                e.addr = base + 4 * k;
                exp_q.push_back(e);
            end
            m_valid[idx] = 1'b1;
            m_tag[idx]   = tag;
            m_dirty[idx] = 1'b0;
        end
        e = quietCycle(1'b0);
        e.resp = 1'b1;
        w = ref_mem[addr[13:2]];
        if (wr) begin
            if (mask == 3'b000 || mask == 3'b001 || mask == 3'b010) begin
                ref_mem[addr[13:2]] = storeMerge(w, addr, mask, wdata);
                m_dirty[idx] = 1'b1;
            end
        end else begin
            e.rdata = loadExtract(w, addr, mask);
        end
        exp_q.push_back(e);
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Cycle-by-cycle comparison against the predicted trace; an empty trace means quiet and ready
    always @(negedge clk) begin : compare
        exp_t e;
        if (check_en) begin
            if (exp_q.size() > 0) e = exp_q.pop_front();
            else                  e = quietCycle(1'b1);
            checkOutput("req_ready", {31'd0, req_ready}, {31'd0, e.ready});
            checkOutput("resp_valid", {31'd0, resp_valid}, {31'd0, e.resp});
            checkOutput("mem_rd_en", {31'd0, mem_rd_en}, {31'd0, e.rd});
            checkOutput("mem_wr_en", {31'd0, mem_wr_en}, {31'd0, e.wr});
            if (e.resp) checkOutput("resp_rdata", resp_rdata, e.rdata);
            if (e.rd || e.wr) checkOutput("mem_addr", mem_addr, e.addr);
            if (e.wr) checkOutput("mem_wdata", mem_wdata, e.wdata);
            if (resp_valid) begin
                last_rdata = resp_rdata;
                last_lat   = cyc - accept_cyc + 1;
            end
        end
    end

    task automatic applyStimulus(input bit wr, input logic [2:0] mask, input logic [31:0] addr,
                                 input logic [31:0] wdata);
        modelRequest(wr, mask, addr, wdata);
        last_rdata = 32'hDEAD_0BAD;
        last_lat   = -1;
        req_valid  = 1'b1;
        req_wr     = wr;
        req_mask   = mask;
        req_addr   = addr;
        req_wdata  = wdata;
        @(posedge clk);
        #1;
        accept_cyc = cyc;
        req_valid  = 1'b0;
    endtask

    task automatic waitIdle();
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (exp_q.size() > 0) begin
            checkOutput("trace drained", exp_q.size(), 0);
            exp_q.delete();
        end
    endtask

    task automatic access(input bit wr, input logic [2:0] mask, input logic [31:0] addr,
                          input logic [31:0] wdata);
        applyStimulus(wr, mask, addr, wdata);
        waitIdle();
    endtask

    task automatic accessPinned(input string name, input bit wr, input logic [2:0] mask,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input bit pin_data, input logic [31:0] lit_data, input int lit_lat);
        access(wr, mask, addr, wdata);
        if (pin_data) checkOutput({name, " data"}, last_rdata, lit_data);
        checkOutput({name, " latency"}, last_lat, lit_lat);
    endtask

    initial begin
        reset     = 1'b0;
        req_valid = 1'b0;
        req_wr    = 1'b0;
        req_mask  = 3'b000;
        req_addr  = '0;
        req_wdata = '0;
        for (int i = 0; i < MEM_WORDS; i++) ref_mem[i] = initWord(i);
        for (int i = 0; i < LINES; i++) begin
            m_valid[i] = 1'b0;
            m_dirty[i] = 1'b0;
            m_tag[i]   = '0;
        end

        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset mem_rd_en", {31'd0, mem_rd_en}, 0);
        checkOutput("reset mem_wr_en", {31'd0, mem_wr_en}, 0);
        checkOutput("reset mem_addr", mem_addr, 0);
        checkOutput("reset mem_wdata", mem_wdata, 0);
        checkOutput("reset resp_valid", {31'd0, resp_valid}, 0);
        checkOutput("reset resp_rdata", resp_rdata, 0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("ready after release", {31'd0, req_ready}, 1);
        check_en = 1'b1;

        accessPinned("lw 0x100 clean miss", 1'b0, 3'b010, 32'h100, 0, 1'b1, 32'h80FF_7F01, 5);
        accessPinned("lb 0x102", 1'b0, 3'b000, 32'h102, 0, 1'b1, 32'hFFFF_FFFF, 1);
        accessPinned("lbu 0x103", 1'b0, 3'b100, 32'h103, 0, 1'b1, 32'h0000_0080, 1);
        accessPinned("lh 0x102", 1'b0, 3'b001, 32'h102, 0, 1'b1, 32'hFFFF_80FF, 1);
        accessPinned("lhu 0x100", 1'b0, 3'b101, 32'h100, 0, 1'b1, 32'h0000_7F01, 1);
        access(1'b0, 3'b010, 32'h104, 0);

        accessPinned("sb 0x101", 1'b1, 3'b000, 32'h101, 32'h0000_00AB, 1'b1, 32'h0, 1);
        accessPinned("lw after sb", 1'b0, 3'b010, 32'h100, 0, 1'b1, 32'h80FF_AB01, 1);
        access(1'b1, 3'b001, 32'h10A, 32'h0000_1234);
        access(1'b1, 3'b010, 32'h10C, 32'hDEAD_BEEF);
        accessPinned("lhu 0x10A", 1'b0, 3'b101, 32'h10A, 0, 1'b1, 32'h0000_1234, 1);
        accessPinned("lh 0x10E", 1'b0, 3'b001, 32'h10E, 0, 1'b1, 32'hFFFF_DEAD, 1);

        accessPinned("lw 0x1100 dirty miss", 1'b0, 3'b010, 32'h1100, 0, 1'b0, 0, 9);
        accessPinned("lw 0x100 after wb", 1'b0, 3'b010, 32'h100, 0, 1'b1, 32'h80FF_AB01, 5);
        accessPinned("lw 0x10C after wb", 1'b0, 3'b010, 32'h10C, 0, 1'b1, 32'hDEAD_BEEF, 1);

        accessPinned("mask 011 load hit", 1'b0, 3'b011, 32'h100, 0, 1'b1, 32'h0, 1);
        accessPinned("lw after bad load", 1'b0, 3'b010, 32'h100, 0, 1'b1, 32'h80FF_AB01, 1);
        accessPinned("store mask 100", 1'b1, 3'b100, 32'h100, 32'h0000_0055, 1'b1, 32'h0, 1);
        accessPinned("lw after bad store", 1'b0, 3'b010, 32'h100, 0, 1'b1, 32'h80FF_AB01, 1);
        accessPinned("conflict stays clean", 1'b0, 3'b010, 32'h1100, 0, 1'b0, 0, 5);
        accessPinned("mask 111 load miss", 1'b0, 3'b111, 32'h480, 0, 1'b1, 32'h0, 5);

        accessPinned("sb 0x205 store miss", 1'b1, 3'b000, 32'h205, 32'h0000_005A, 1'b1, 32'h0, 5);
        accessPinned("lbu 0x205", 1'b0, 3'b100, 32'h205, 0, 1'b1, 32'h0000_005A, 1);

        // Abort a refill during its third beat
        applyStimulus(1'b0, 3'b010, 32'h340, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        check_en = 1'b0;
        checkOutput("fill beat2 rd_en", {31'd0, mem_rd_en}, 1);
        checkOutput("fill beat2 addr", mem_addr, 32'h348);
        exp_q.delete();
        reset = 1'b0;
        #1;
        checkOutput("abort mem_rd_en", {31'd0, mem_rd_en}, 0);
        checkOutput("abort mem_wr_en", {31'd0, mem_wr_en}, 0);
        checkOutput("abort mem_addr", mem_addr, 0);
        checkOutput("abort resp_valid", {31'd0, resp_valid}, 0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        // All lines are dropped, so the core now sees exactly what memory holds
        for (int i = 0; i < LINES; i++) begin
            m_valid[i] = 1'b0;
            m_dirty[i] = 1'b0;
        end
        for (int i = 0; i < MEM_WORDS; i++) ref_mem[i] = mem[i];
        @(posedge clk);
        #1;
        checkOutput("ready after abort", {31'd0, req_ready}, 1);
        check_en = 1'b1;

        accessPinned("lw 0x340 re-miss", 1'b0, 3'b010, 32'h340, 0, 1'b0, 0, 5);
        accessPinned("lbu 0x205 lost line", 1'b0, 3'b100, 32'h205, 0, 1'b0, 0, 5);

        repeat (2) @(posedge clk);
        #1;
        check_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
